mpeg_es_buffer: RTL

// Buffers elementary-stream bytes emitted by the MPEG demuxer (bytes qualified by mpeg_packet_body).

---
 rtl/mpeg_es_buffer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mpeg_es_buffer.sv
// mpeg_es_buffer: elementary-stream byte FIFO with DTS-gated release.
// Define MPEG_ES_BUFFER_TIMING_EN to build the tag FIFO and HOLD gating.
module mpeg_es_buffer #(
  parameter int ADDR_W     = 11,
  parameter int TAG_ADDR_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  input  logic            in_body,
  input  logic [32:0]     dts,
  input  logic            dts_updated,
  input  logic [32:0]     scr_start,
  input  logic            scr_start_ok,
  input  logic [31:0]     dclk,
  input  logic            flush,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  output logic            tag_overflow
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    HOLD
  } state_t;

  logic [7:0]      r_mem [DEPTH];
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_body_q;
  logic            r_out_valid;
  logic [7:0]      r_out_data;
  logic            r_overflow;
  state_t          r_state;
  state_t          w_state_nx;

  logic w_clr;
  logic w_full;
  logic w_empty;
  logic w_wr_req;
  logic w_wr_en;
  logic w_pkt_start;
  logic w_out_free;
  logic w_pop;
  logic w_tag_hit;
  logic w_tag_due;
  logic w_tag_pop;

  assign w_clr = reset | flush;

  assign w_full =
    (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_wr_req    = in_valid & in_body;
  assign w_wr_en     = w_wr_req & ~w_full;
  assign w_pkt_start = w_wr_en & ~r_body_q;
  assign w_out_free  = ~r_out_valid | out_ready;

`ifdef MPEG_ES_BUFFER_TIMING_EN
  localparam int TDEPTH = 1 << TAG_ADDR_W;

  logic [31:0]         r_tag_dts  [TDEPTH];
  logic [ADDR_W-1:0]   r_tag_addr [TDEPTH];
  logic [TAG_ADDR_W:0] r_twr_ptr;
  logic [TAG_ADDR_W:0] r_trd_ptr;
  logic [ADDR_W-1:0]   r_pkt_addr;
  logic                r_tag_ovf;

  logic                w_tfull;
  logic                w_tempty;
  logic [ADDR_W-1:0]   w_pkt_addr;
  logic [31:0]         w_head_dts;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [32:0]         w_now;
  logic [32:0]         w_diff;
  logic                w_unused_lsb;

  assign w_unused_lsb = scr_start[0] ^ dts[0];

  assign w_tfull =
    (r_twr_ptr[TAG_ADDR_W] != r_trd_ptr[TAG_ADDR_W]) &&
    (r_twr_ptr[TAG_ADDR_W-1:0] ==
     r_trd_ptr[TAG_ADDR_W-1:0]);

  assign w_tempty = (r_twr_ptr == r_trd_ptr);

  // a tag in the same cycle as its packet's first byte still points at it
  assign w_pkt_addr = w_pkt_start ?
    r_wr_ptr[ADDR_W-1:0] : r_pkt_addr;

  assign w_head_dts  = r_tag_dts[r_trd_ptr[TAG_ADDR_W-1:0]];
  assign w_head_addr = r_tag_addr[r_trd_ptr[TAG_ADDR_W-1:0]];

  assign w_now  = {1'b0, dclk} - {1'b0, scr_start[32:1]};
  assign w_diff = w_now - {1'b0, w_head_dts};

  assign w_tag_due = scr_start_ok && ($signed(w_diff) >= 0);

  assign w_tag_hit = ~w_tempty &&
    (r_rd_ptr[ADDR_W-1:0] == w_head_addr);

  always_ff @(posedge clk) begin
    if (dts_updated && !w_tfull) begin
      r_tag_dts[r_twr_ptr[TAG_ADDR_W-1:0]]  <= dts[32:1];
      r_tag_addr[r_twr_ptr[TAG_ADDR_W-1:0]] <= w_pkt_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_twr_ptr  <= '0;
      r_trd_ptr  <= '0;
      r_pkt_addr <= '0;
      r_tag_ovf  <= 1'b0;
    end else begin
      if (w_pkt_start)
        r_pkt_addr <= r_wr_ptr[ADDR_W-1:0];
      if (dts_updated) begin
        if (w_tfull)
          r_tag_ovf <= 1'b1;
        else
          r_twr_ptr <= r_twr_ptr + 1'b1;
      end
      if (w_tag_pop)
        r_trd_ptr <= r_trd_ptr + 1'b1;
    end
  end

  assign tag_overflow = r_tag_ovf;
`else
  logic w_unused_timing;

  assign w_unused_timing = ^{dts, dts_updated, scr_start,
                             scr_start_ok, dclk};

  assign w_tag_hit    = 1'b0;
  assign w_tag_due    = 1'b0;
  assign tag_overflow = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_tag_pop  = 1'b0;
    unique case (r_state)
      IDLE, STREAM: begin
        if (w_empty) begin
          w_state_nx = IDLE;
        end else if (w_tag_hit) begin
          w_state_nx = HOLD;
        end else begin
          w_state_nx = STREAM;
          w_pop      = w_out_free;
        end
      end
      HOLD: begin
        if (w_tag_due) begin
          w_tag_pop  = 1'b1;
          w_state_nx = STREAM;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_body_q    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (in_valid)
        r_body_q <= in_body;
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_wr_req && w_full)
        r_overflow <= 1'b1;
      if (w_pop) begin
        r_out_data  <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
  assign level     = r_wr_ptr - r_rd_ptr;

endmodule
